// File: rtl/ym_serial_pkg.sv
// rtl/ym_serial_pkg.sv - shared widths and float-to-linear conversion for the YM serial DAC stream
package ym_serial_pkg;

  localparam int MANT_W = 10;
  localparam int EXP_W  = 3;
  localparam int WORD_W = 13;
  localparam int LIN_W  = 16;

  // Exponent 0 is not a legal code and maps to silence.
  function automatic logic [LIN_W-1:0] ym_float_to_lin(input logic [WORD_W-1:0] word);
    logic [EXP_W-1:0] e;
    logic [LIN_W-1:0] m;
    e = word[WORD_W-1:MANT_W];
    m = {{(LIN_W-MANT_W){1'b0}}, word[MANT_W-1:0]};
    if (e == '0) return '0;
    return m << (e - 3'd1);
  endfunction

endpackage

// File: rtl/ym_sh_sync.sv
// rtl/ym_sh_sync.sv - synchronisers for p1/sh/so and p1 rising-edge detect
module ym_sh_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ym_p1_i,
  input  logic sh_i,
  input  logic so_i,
  output logic p1e_o,
  output logic sh_s_o,
  output logic so_s_o
);

  logic [SYNC_STAGES-1:0] p1_q;
  logic [SYNC_STAGES-1:0] sh_q;
  logic [SYNC_STAGES-1:0] so_q;
  logic                   p1_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q      <= '0;
      sh_q      <= '0;
      so_q      <= '0;
      p1_prev_q <= 1'b0;
    end else begin
      p1_q      <= {p1_q[SYNC_STAGES-2:0], ym_p1_i};
      sh_q      <= {sh_q[SYNC_STAGES-2:0], sh_i};
      so_q      <= {so_q[SYNC_STAGES-2:0], so_i};
      p1_prev_q <= p1_q[SYNC_STAGES-1];
    end
  end

  assign p1e_o  = p1_q[SYNC_STAGES-1] & ~p1_prev_q;
  assign sh_s_o = sh_q[SYNC_STAGES-1];
  assign so_s_o = so_q[SYNC_STAGES-1];

endmodule

// File: rtl/ym_serial_decode.sv
// rtl/ym_serial_decode.sv - YM serial DAC receiver: deserialise, frame check, float-to-linear decode
module ym_serial_decode
  import ym_serial_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_LEN   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ym_p1,
  input  logic             sh,
  input  logic             so,
  input  logic             err_clr,
  output logic [LIN_W-1:0] linear,
  output logic             valid,
  output logic             frame_err
);

  logic              p1e, sh_s, so_s, sh_fall;
  logic [WORD_W-1:0] shreg_q, shreg_d, word_q, word_d;
  logic [4:0]        cnt_q, cnt_d;
  logic              sh_prev_q, sh_prev_d, first_q, first_d;
  logic              cap_q, cap_d, valid_q, valid_d, err_q, err_d;
  logic [LIN_W-1:0]  lin_q, lin_d;
  logic              len_bad, exp_bad;

  ym_sh_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .ym_p1_i (ym_p1),
    .sh_i    (sh),
    .so_i    (so),
    .p1e_o   (p1e),
    .sh_s_o  (sh_s),
    .so_s_o  (so_s)
  );

  assign sh_fall = p1e & sh_prev_q & ~sh_s;
  assign len_bad = sh_fall & ~first_q & (cnt_q != 5'(FRAME_LEN));
  assign exp_bad = cap_q & (word_q[WORD_W-1:MANT_W] == '0);

  always_comb begin
    shreg_d   = shreg_q;
    word_d    = word_q;
    cnt_d     = cnt_q;
    sh_prev_d = sh_prev_q;
    first_d   = first_q;
    cap_d     = 1'b0;
    valid_d   = 1'b0;
    lin_d     = lin_q;
    err_d     = err_q;
    if (p1e) begin
      shreg_d   = {so_s, shreg_q[WORD_W-1:1]};
      sh_prev_d = sh_s;
      cnt_d     = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
    end
    // A first fall with fewer than a word's worth of shifts since reset closes a
    // partial word (reset landed mid-frame), so it only establishes framing.
    if (sh_fall) begin
      cnt_d   = 5'd1;
      first_d = 1'b0;
      if (!first_q || cnt_q >= 5'(WORD_W)) begin
        word_d = shreg_q;
        cap_d  = 1'b1;
      end
    end
    if (cap_q) begin
      lin_d   = ym_float_to_lin(word_q);
      valid_d = 1'b1;
    end
    if (err_clr) err_d = 1'b0;
    if (len_bad || exp_bad) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q   <= '0;
      word_q    <= '0;
      cnt_q     <= '0;
      sh_prev_q <= 1'b0;
      first_q   <= 1'b1;
      cap_q     <= 1'b0;
      valid_q   <= 1'b0;
      lin_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      cnt_q     <= cnt_d;
      sh_prev_q <= sh_prev_d;
      first_q   <= first_d;
      cap_q     <= cap_d;
      valid_q   <= valid_d;
      lin_q     <= lin_d;
      err_q     <= err_d;
    end
  end

  assign linear    = lin_q;
  assign valid     = valid_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_ym_serial_decode.sv
// tb/tb_ym_serial_decode.sv - directed bench for ym_serial_decode with a serial stream encoder
module tb_ym_serial_decode;
  import ym_serial_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ym_p1 = 1'b0;
  logic        sh = 1'b0;
  logic        so = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] linear;
  logic        valid;
  logic        frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int vcount = 0;

  ym_serial_decode #(.SYNC_STAGES(2), .FRAME_LEN(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ym_p1     (ym_p1),
    .sh        (sh),
    .so        (so),
    .err_clr   (err_clr),
    .linear    (linear),
    .valid     (valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) vcount++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] enc(input logic [15:0] v);
    int e;
    logic [15:0] m;
    e = 1;
    for (int b = 15; b >= 10; b--)
      if (v[b] && e == 1) e = b - 8;
    m = v >> (e - 1);
    return {3'(e), m[9:0]};
  endfunction

  // n p1 edges per frame: fillers with sh high, 13 data bits LSB first, then the sh-low edge.
  task automatic send_frame(input logic [12:0] w, input int n, input int rst_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ym_p1 = 1'b0;
      sh    = (k == n - 1) ? 1'b0 : 1'b1;
      so    = (k >= n - 14 && k < n - 1) ? w[k - (n - 14)] : 1'b0;
      repeat (3) @(negedge clk);
      ym_p1 = 1'b1;
      if (k == rst_at) begin
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic run(input string tag, input logic [12:0] w, input int n, input int rst_at,
                     input logic [15:0] exp_lin, input int exp_nv, input logic exp_err);
    int v0;
    v0 = vcount;
    send_frame(w, n, rst_at);
    repeat (6) @(negedge clk);
    check({tag, "_lin"}, linear, exp_lin);
    check({tag, "_nvalid"}, vcount - v0, exp_nv);
    check({tag, "_err"}, frame_err, exp_err);
  endtask

  initial begin
    logic [15:0] v, lin_m;
    logic [12:0] w;
    int e;

    repeat (4) @(negedge clk);
    check("rst_linear", linear, 16'h0000);
    check("rst_valid", valid, 1'b0);
    check("rst_err", frame_err, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check("enc_8000", enc(16'h8000), 13'h1E00);
    run("f8000a", 13'h1E00, 16, -1, 16'h8000, 1, 1'b0);
    run("f8000b", 13'h1E00, 16, -1, 16'h8000, 1, 1'b0);
    check("enc_1234", enc(16'h1234), 13'h1246);
    run("f1234", 13'h1246, 16, -1, 16'h1230, 1, 1'b0);
    run("f0123", 13'h0523, 16, -1, 16'h0123, 1, 1'b0);
    run("fffff", 13'h1FFF, 16, -1, 16'hFFC0, 1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      v = 16'((i < 6 ? i : 11 - i) * 12000 + 1 + i);
      w = enc(v);
      e = int'(w[12:10]);
      lin_m = ym_float_to_lin(w);
      run("ramp", w, 16, -1, lin_m, 1, 1'b0);
      check("ramp_trunc", ((int'(v) - int'(linear)) < (1 << (e - 1))), 1'b1);
    end

    run("short15", 13'h0523, 15, -1, 16'h0123, 1, 1'b1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(negedge clk);
    check("err_clr", frame_err, 1'b0);
    run("after_clr", 13'h1E00, 16, -1, 16'h8000, 1, 1'b0);

    run("exp0", 13'h0155, 16, -1, 16'h0000, 1, 1'b1);
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
    @(negedge clk);
    check("err_clr2", frame_err, 1'b0);
    run("pre_rst", 13'h1246, 16, -1, 16'h1230, 1, 1'b0);

    run("mid_rst", 13'h1246, 16, 8, 16'h0000, 0, 1'b0);
    run("post_rst", 13'h1E00, 16, -1, 16'h8000, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
